// File: rtl/irq_responder.sv
// Interrupt acceptance and return sequencer: accepts a pending IRQ at an
// instruction boundary, redirects fetch to its vector, and returns on mret.
module irq_responder #(
  parameter int IRQ_NUM_POW = 4,
  parameter int HOLDOFF     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   irq_req_i,
  input  logic [IRQ_NUM_POW-1:0] irq_code_bi,
  output logic                   irq_ack_o,
  input  logic                   instr_boundary_i,
  input  logic [31:0]            pc_bi,
  input  logic [31:0]            ivec_base_bi,
  input  logic                   mret_i,
  input  logic                   ie_wr_i,
  input  logic                   ie_wdata_i,
  output logic                   ie_o,
  output logic                   redirect_o,
  output logic [31:0]            redirect_addr_bo,
  output logic [31:0]            epc_bo,
  output logic [IRQ_NUM_POW-1:0] cause_bo,
  output logic                   in_service_o
);

  localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, REDIRECT, SERVICE, RETURN} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [HW-1:0]          r_holdoff;
  logic                   r_ie;
  logic [31:0]            r_epc;
  logic [IRQ_NUM_POW-1:0] r_cause;
  logic                   w_accept;
  logic                   w_mret_svc;
  logic [31:0]            w_vec_off;

  assign w_vec_off = {{(32-IRQ_NUM_POW){1'b0}}, r_cause} << 2;

  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_mret_svc       = 1'b0;
    redirect_o       = 1'b0;
    redirect_addr_bo = 32'h0;
    in_service_o     = 1'b0;
    case (r_state)
      IDLE: begin
        // r_ie is the pre-cycle value, so a same-cycle ie write cannot gate this
        if (!rst_i && irq_req_i && r_ie && instr_boundary_i && (r_holdoff == '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_o       = 1'b1;
        redirect_addr_bo = ivec_base_bi + w_vec_off;
        w_state_nxt      = SERVICE;
      end
      SERVICE: begin
        in_service_o = 1'b1;
        if (mret_i) begin
          w_mret_svc  = 1'b1;
          w_state_nxt = RETURN;
        end
      end
      RETURN: begin
        redirect_o       = 1'b1;
        redirect_addr_bo = r_epc;
        w_state_nxt      = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_holdoff <= '0;
      r_ie      <= 1'b0;
      r_epc     <= 32'h0;
      r_cause   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RETURN)
        r_holdoff <= HW'(HOLDOFF);
      else if ((r_state == IDLE) && (r_holdoff != '0))
        r_holdoff <= r_holdoff - HW'(1);
      // accept/mret updates take priority over a software write
      if (w_accept)
        r_ie <= 1'b0;
      else if (w_mret_svc)
        r_ie <= 1'b1;
      else if (ie_wr_i)
        r_ie <= ie_wdata_i;
      if (w_accept) begin
        r_epc   <= pc_bi;
        r_cause <= irq_code_bi;
      end
    end
  end

  assign irq_ack_o = w_accept;
  assign ie_o      = r_ie;
  assign epc_bo    = r_epc;
  assign cause_bo  = r_cause;

endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder: acceptance, gating, return holdoff,
// priority conflicts, vector wrap and mid-service reset.
module tb_irq_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic [3:0]  code;
  logic        ack;
  logic        bnd;
  logic [31:0] pc;
  logic [31:0] base;
  logic        mret;
  logic        ie_wr;
  logic        ie_wd;
  logic        ie;
  logic        redir;
  logic [31:0] raddr;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        insvc;

  int n_vec = 0;
  int n_mis = 0;

  irq_responder #(.IRQ_NUM_POW(4), .HOLDOFF(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .irq_req_i        (req),
    .irq_code_bi      (code),
    .irq_ack_o        (ack),
    .instr_boundary_i (bnd),
    .pc_bi            (pc),
    .ivec_base_bi     (base),
    .mret_i           (mret),
    .ie_wr_i          (ie_wr),
    .ie_wdata_i       (ie_wd),
    .ie_o             (ie),
    .redirect_o       (redir),
    .redirect_addr_bo (raddr),
    .epc_bo           (epc),
    .cause_bo         (cause),
    .in_service_o     (insvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; code = 4'd0; bnd = 1'b0; pc = 32'h0;
    base = 32'h0; mret = 1'b0; ie_wr = 1'b0; ie_wd = 1'b0;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_redir", 32'(redir), 32'd0);
    chk("rst_insvc", 32'(insvc), 32'd0);
    chk("rst_ie", 32'(ie), 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", 32'(cause), 32'd0);
    rst = 1'b0;

    // gating: ie=0
    req = 1'b1; code = 4'd5; bnd = 1'b1; pc = 32'h200; base = 32'h1000;
    #1;
    chk("gate_ie_ack", 32'(ack), 32'd0);
    tick();
    chk("gate_ie_redir", 32'(redir), 32'd0);
    // gating: boundary=0 while ie is written to 1
    bnd = 1'b0; ie_wr = 1'b1; ie_wd = 1'b1;
    #1;
    chk("gate_bnd_ack0", 32'(ack), 32'd0);
    tick();
    ie_wr = 1'b0;
    #1;
    chk("gate_ie_set", 32'(ie), 32'd1);
    chk("gate_bnd_ack1", 32'(ack), 32'd0);
    tick();
    chk("gate_bnd_redir", 32'(redir), 32'd0);

    // accept at T with a conflicting ie write of 1
    bnd = 1'b1; ie_wr = 1'b1; ie_wd = 1'b1;
    #1;
    chk("T_ack", 32'(ack), 32'd1);
    tick();
    ie_wr = 1'b0; pc = 32'h300; code = 4'd3;
    #1;
    chk("T1_redir", 32'(redir), 32'd1);
    chk("T1_addr", raddr, 32'h1014);
    chk("T1_ie_conflict", 32'(ie), 32'd0);
    chk("T1_epc", epc, 32'h200);
    chk("T1_cause", 32'(cause), 32'd5);
    chk("T1_insvc", 32'(insvc), 32'd0);
    chk("T1_ack", 32'(ack), 32'd0);
    tick();
    chk("T2_insvc", 32'(insvc), 32'd1);
    chk("T2_redir", 32'(redir), 32'd0);
    chk("T2_addr0", raddr, 32'h0);
    chk("T2_ack_ignored", 32'(ack), 32'd0);
    chk("T2_epc_hold", epc, 32'h200);
    tick();
    chk("T3_ack_ignored", 32'(ack), 32'd0);

    // mret at M
    mret = 1'b1;
    tick();
    mret = 1'b0;
    #1;
    chk("M1_redir", 32'(redir), 32'd1);
    chk("M1_addr", raddr, 32'h200);
    chk("M1_ie", 32'(ie), 32'd1);
    chk("M1_insvc", 32'(insvc), 32'd0);
    chk("M1_ack", 32'(ack), 32'd0);
    tick();
    chk("M2_ack", 32'(ack), 32'd0);
    chk("M2_redir", 32'(redir), 32'd0);
    tick();
    chk("M3_ack", 32'(ack), 32'd0);
    tick();
    chk("M4_ack", 32'(ack), 32'd1);
    tick();
    chk("acc2_addr", raddr, 32'h100C);
    chk("acc2_cause", 32'(cause), 32'd3);
    chk("acc2_epc", epc, 32'h300);
    tick();
    chk("acc2_insvc", 32'(insvc), 32'd1);

    // reset while in SERVICE, with req and an ie write pending
    rst = 1'b1; ie_wr = 1'b1; ie_wd = 1'b1;
    tick();
    chk("rs_insvc", 32'(insvc), 32'd0);
    chk("rs_redir", 32'(redir), 32'd0);
    chk("rs_ie", 32'(ie), 32'd0);
    chk("rs_epc", epc, 32'h0);
    chk("rs_cause", 32'(cause), 32'd0);
    chk("rs_ack", 32'(ack), 32'd0);
    rst = 1'b0; ie_wr = 1'b0;
    #1;
    chk("rs_post_ack", 32'(ack), 32'd0);
    tick();
    chk("rs_post_redir", 32'(redir), 32'd0);

    // write ie back, then accept with vector wrap
    ie_wr = 1'b1; ie_wd = 1'b1; code = 4'd15; pc = 32'h400; base = 32'hFFFF_FFF0;
    tick();
    ie_wr = 1'b0;
    #1;
    chk("wrap_ack", 32'(ack), 32'd1);
    tick();
    chk("wrap_redir", 32'(redir), 32'd1);
    chk("wrap_addr", raddr, 32'h0000_002C);
    chk("wrap_cause", 32'(cause), 32'd15);
    chk("wrap_epc", epc, 32'h400);
    tick();
    req = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    chk("ret_idle_insvc", 32'(insvc), 32'd0);

    // mret in IDLE has no effect
    ie_wr = 1'b1; ie_wd = 1'b0;
    tick();
    ie_wr = 1'b0;
    chk("idle_ie_clr", 32'(ie), 32'd0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    #1;
    chk("idle_mret_ie", 32'(ie), 32'd0);
    chk("idle_mret_redir", 32'(redir), 32'd0);
    chk("idle_mret_insvc", 32'(insvc), 32'd0);
    chk("epc_hold", epc, 32'h400);
    chk("cause_hold", 32'(cause), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
